// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit and receive paths.
//   uart_state_e : 2-bit frame FSM encoding (IDLE/START/DATA/STOP)
//   DATA_BITS    : payload bits per frame (8N1)
//   STOP_BITS    : stop bits per frame
//   baud_div()   : clock cycles per bit, integer-truncated
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with count-based flags.
//   clk, reset  : clock, synchronous active-high reset
//   wr_en/wr_data : push request; ignored (and flagged) while full
//   rd_en/rd_data : pop request; rd_data shows the head entry
//   full, empty : registered occupancy flags after the current edge
//   overflow    : one-cycle pulse after a push was dropped
//   empty_nxt   : combinational empty value the next edge will load
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             empty_nxt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             push, pop;

  // full is the registered flag, so a pop in the same cycle never frees
  // room for a push that arrives while full.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  assign empty_nxt = (count_nxt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(DEPTH));
      empty    <= empty_nxt;
      overflow <= wr_en && full;
      // DEPTH is a power of two: pointers wrap on their own.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_byte_transmitter.sv
// uart_byte_transmitter -- buffered 8N1 UART transmitter.
//   CLOCK_50  : clock (all logic on rising edge)
//   reset     : synchronous active-high reset; truncates any frame
//   in        : byte to queue, sampled while send_flag=1
//   send_flag : one push per high cycle
//   UART_TX   : registered serial line, idles high, LSB first
//   busy      : FSM not idle or FIFO non-empty (registered)
//   full/empty: FIFO flags (registered)
//   overflow  : one-cycle pulse after a dropped push
module uart_byte_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] in,
  input  logic       send_flag,
  output logic       UART_TX,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  uart_state_e          state, state_n;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [7:0]           fifo_head;
  logic                 fifo_empty_nxt;
  logic                 pop, baud_done, last_data, last_stop;
  logic                 tx_d, tx_q, busy_d, busy_q;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .reset    (reset),
    .wr_en    (send_flag),
    .wr_data  (in),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .empty_nxt(fifo_empty_nxt)
  );

  assign baud_done = (baud_cnt == CNT_W'(DIV - 1));
  assign last_data = (bit_idx == BIT_W'(DATA_BITS - 1));
  assign last_stop = (bit_idx == BIT_W'(STOP_BITS - 1));

  // FSM: state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM: next state; pops happen only when entering START
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = START;
      end
      START: if (baud_done) state_n = DATA;
      DATA:  if (baud_done && last_data) state_n = STOP;
      STOP:  if (baud_done && last_stop) begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;   // back-to-back frame, no idle gap
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs. The line register is loaded from the post-edge state
  // and shifter so UART_TX lines up with the state it belongs to.
  always_comb begin
    shift_n = shift;
    if (pop)                           shift_n = fifo_head;
    else if (state == DATA && baud_done) shift_n = shift >> 1;

    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_n[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_n != IDLE) || !fifo_empty_nxt;
  end

  // Baud counter, bit index, shifter and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      // every bit/phase boundary coincides with baud_done, so wrapping
      // there also clears the count on each state or bit change
      baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + CNT_W'(1);
      if (state_n != state)                  bit_idx <= '0;
      else if (baud_done && state != IDLE)   bit_idx <= bit_idx + BIT_W'(1);
      shift    <= shift_n;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign UART_TX = tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
module tb_uart_byte_transmitter;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_flag = 1'b0;
  logic [7:0] din = '0;
  logic       uart_tx, busy, full, empty, overflow;

  uart_byte_transmitter #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .in       (din),
    .send_flag(send_flag),
    .UART_TX  (uart_tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: queue of accepted bytes plus the time window of the
  // frame on the line. Line level is derived from (cycle - frame start).
  logic [7:0] q[$];
  bit         m_act = 1'b0;
  int         fs = 0;
  logic [7:0] cur = '0;
  bit         m_ovf = 1'b0;

  typedef struct {
    int   c;
    logic tx;
    logic busy;
    logic empty;
  } vec_t;
  vec_t tbl[$];

  function automatic logic exp_tx(input int c);
    int k;
    if (!m_act) return 1'b1;
    k = (c - fs) / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    bit full_pre;
    if (reset) begin
      q.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
      return;
    end
    full_pre = (q.size() == DEPTH);
    m_ovf = 1'b0;
    if (m_act && cyc == fs + FRAME - 1) m_act = 1'b0;
    if (!m_act && q.size() > 0) begin
      cur   = q.pop_front();
      fs    = cyc + 1;
      m_act = 1'b1;
    end
    if (send_flag) begin
      if (full_pre) m_ovf = 1'b1;
      else          q.push_back(din);
    end
  endtask

  // Check this cycle against the model, advance the model, then the clock.
  task automatic step();
    logic [4:0] e;
    e = {exp_tx(cyc), (m_act || q.size() > 0), (q.size() == DEPTH), (q.size() == 0), m_ovf};
    chk("model tx/busy/full/empty/ovf", {27'd0, uart_tx, busy, full, empty, overflow}, {27'd0, e});
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    send_flag = 1'b0;
    step();
    reset     = 1'b0;
  endtask

  task automatic addv(input int c, input logic tx, input logic b, input logic e);
    vec_t v;
    v.c = c; v.tx = tx; v.busy = b; v.empty = e;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  base, ovf_cnt, fall, low_cnt, bad, burst;
    bit  prev_busy;

    // 0xA5 = 1010_0101 -> LSB first 1,0,1,0,0,1,0,1; push at cycle 5
    addv(0,   1, 0, 1);  addv(5,   1, 0, 1);  addv(6,   1, 1, 0);
    addv(7,   0, 1, 1);  addv(16,  0, 1, 1);  addv(17,  1, 1, 1);
    addv(26,  1, 1, 1);  addv(27,  0, 1, 1);  addv(36,  0, 1, 1);
    addv(37,  1, 1, 1);  addv(47,  0, 1, 1);  addv(57,  0, 1, 1);
    addv(67,  1, 1, 1);  addv(77,  0, 1, 1);  addv(87,  1, 1, 1);
    addv(96,  1, 1, 1);  addv(97,  1, 1, 1);  addv(106, 1, 1, 1);
    addv(107, 1, 0, 1);

    // bootstrap: outputs are unknown before the first reset edge
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;

    // 1: single frame, table-driven checkpoints
    base = cyc;
    for (int r = 0; r <= 110; r++) begin
      send_flag = (r == 5);
      din = 8'hA5;
      if (r == 0) begin
        chk("reset_full", full, 0);
        chk("reset_overflow", overflow, 0);
      end
      foreach (tbl[i]) if (tbl[i].c == r) begin
        chk("s1_tx", uart_tx, tbl[i].tx);
        chk("s1_busy", busy, tbl[i].busy);
        chk("s1_empty", empty, tbl[i].empty);
      end
      step();
    end

    // 2: three back-to-back frames
    do_reset();
    fall = -1; prev_busy = 1'b0;
    for (int r = 0; r <= 310; r++) begin
      send_flag = (r >= 2 && r <= 4);
      din = (r == 2) ? 8'h00 : (r == 3) ? 8'hFF : 8'h3C;
      if (r == 103) chk("s2_stop1_tx", uart_tx, 1);
      if (r == 104) chk("s2_start2_tx", uart_tx, 0);
      if (r == 203) begin chk("s2_stop2_tx", uart_tx, 1); chk("s2_empty_before", empty, 0); end
      if (r == 204) begin chk("s2_start3_tx", uart_tx, 0); chk("s2_empty_after", empty, 1); end
      if (!busy && prev_busy && fall < 0) fall = r;
      prev_busy = busy;
      step();
    end
    chk("s2_busy_fall", fall, 2 + 2 + 3 * FRAME);

    // 3: six pushes into a four-entry FIFO
    do_reset();
    ovf_cnt = 0; fall = -1; prev_busy = 1'b0;
    for (int r = 0; r <= 4 + 5 * FRAME + 10; r++) begin
      send_flag = (r >= 2 && r <= 7);
      din = 8'($urandom);
      if (r == 7) chk("s3_full_at_6th", full, 1);
      if (r == 8) chk("s3_overflow", overflow, 1);
      if (overflow) ovf_cnt++;
      if (!busy && prev_busy && fall < 0) fall = r;
      prev_busy = busy;
      step();
    end
    chk("s3_ovf_pulses", ovf_cnt, 1);
    chk("s3_five_frames", fall, 2 + 2 + 5 * FRAME);

    // 4: reset during DATA with two bytes queued
    do_reset();
    low_cnt = 0;
    for (int r = 0; r <= 340; r++) begin
      send_flag = (r >= 2 && r <= 4);
      din = 8'($urandom);
      reset = (r == 39);
      if (r == 39) chk("s4_queued", empty, 0);
      if (r == 40) begin
        chk("s4_tx", uart_tx, 1);
        chk("s4_empty", empty, 1);
        chk("s4_busy", busy, 0);
      end
      if (r >= 40 && !uart_tx) low_cnt++;
      step();
    end
    reset = 1'b0;
    chk("s4_no_frames", low_cnt, 0);

    // 5: push while full on the STOP->START pop cycle
    do_reset();
    fall = -1; prev_busy = 1'b0;
    for (int r = 0; r <= 4 + 5 * FRAME + 10; r++) begin
      send_flag = (r >= 2 && r <= 6) || (r == 103);
      din = 8'($urandom);
      if (r == 103) chk("s5_full", full, 1);
      if (r == 104) begin
        chk("s5_overflow", overflow, 1);
        chk("s5_full_after", full, 0);
        chk("s5_not_empty", empty, 0);
      end
      if (!busy && prev_busy && fall < 0) fall = r;
      prev_busy = busy;
      step();
    end
    chk("s5_five_frames", fall, 2 + 2 + 5 * FRAME);

    // 6: idle line
    do_reset();
    bad = 0;
    for (int r = 0; r < 1000; r++) begin
      send_flag = 1'b0;
      if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
      step();
    end
    chk("s6_idle", bad, 0);

    // randomized traffic against the model
    do_reset();
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 299) == 0) burst = 6;
      send_flag = (burst > 0) || ($urandom_range(0, 39) == 0);
      if (burst > 0) burst--;
      din = 8'($urandom);
      step();
    end
    reset = 1'b0;
    send_flag = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
